branch_predict_ctl: RTL
=======================

# branch_predict_ctl

Parametrised successor to the pipeline's fixed-function branch controller. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, so IF can fetch speculatively. The block sits beside the IF/ID/EX stages. It:
- issues a prediction for the current fetch PC;
- verifies predictions of direct jumps in ID and of conditional/ALU branches in EX;
- resteers and flushes on mispredict;
- trains the table at EX retirement.

With PRED_MODE=0 it is exactly the predict-not-taken controller.

## Interface
- WIDTH, 16, PC/target width
- IDX_BITS, 4, BTB index bits (2^IDX_BITS entries); index = pc[IDX_BITS:1]
- PRED_MODE, 1, 0 = static not-taken (table unused, never allocated), 1 = bimodal BTB
- CNT_W, 16, width of statistics counters

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- IF_pc  in  WIDTH  current fetch PC
- IF_pred_taken  out  1  prediction for IF_pc
- IF_pred_tgt  out  WIDTH  predicted target (0 when not taken)
- ID_flow_ty  in  2  ops.vh flow type of ID instruction (FLOW_NONE/JUMP/COND/ALU)
- ID_dbranch_tgt  in  WIDTH  decoded direct target
- ID_pred_taken, ID_pred_tgt  in  1, WIDTH  prediction carried with ID instruction
- EX_valid  in  1  EX holds a real (non-bubble) instruction
- EX_stall  in  1  EX held this cycle
- EX_flow_ty  in  2  flow type in EX
- EX_pc  in  WIDTH  PC of EX instruction
- EX_dbranch_tgt  in  WIDTH  direct target in EX
- EX_alu_out  in  WIDTH  computed target for FLOW_ALU
- EX_flag  in  1  condition outcome for FLOW_COND
- EX_pred_taken, EX_pred_tgt  in  1, WIDTH  prediction carried with EX instruction
- IF_rewrite_pc  out  1  load IF_pc_rewrite_to into PC this cycle
- IF_pc_rewrite_to  out  WIDTH  redirect PC
- flush_if2id  out  1  squash IF/ID register
- flush_id2ex  out  1  squash ID/EX register
- stat_branches  out  CNT_W  resolved flow instructions in EX
- stat_mispredicts  out  CNT_W  EX resolutions that caused a redirect

## Operation
- BTB entry: valid, tag = pc[WIDTH-1:IDX_BITS+1], target, ctr[1:0].
- Lookup (combinational from registers): hit = valid and tag match. IF_pred_taken = PRED_MODE and hit and ctr[1]. IF_pred_tgt = target if taken, else 0.
- EX check, with act = EX_valid and not EX_stall:
  - FLOW_COND: taken = EX_flag; correct target = EX_dbranch_tgt.
  - FLOW_JUMP: taken = 1; correct target = EX_dbranch_tgt.
  - FLOW_ALU: taken = 1; correct target = EX_alu_out.
  - FLOW_NONE: taken = 0.
  - ex_miss = act and (taken != EX_pred_taken, or taken and EX_pred_tgt != correct target).
  - Redirect = taken ? correct target : EX_pc+2 (modulo 2^WIDTH).
- ID check: id_miss = ID_flow_ty==FLOW_JUMP and not (ID_pred_taken and ID_pred_tgt==ID_dbranch_tgt). Redirect = ID_dbranch_tgt.
- Priority: ex_miss overrides id_miss.
  - ex_miss: IF_rewrite_pc=1, flush_if2id=1, flush_id2ex=1, EX redirect.
  - id_miss only: IF_rewrite_pc=1, flush_if2id=1, flush_id2ex=0.
  - Neither: all three 0; IF_pc_rewrite_to = 0.
- Training (PRED_MODE=1, at the edge where act=1, indexed by EX_pc):
  - Hit, FLOW_COND: ctr saturating ±1 (00..11) by taken; if taken, target <= correct target.
  - Hit, FLOW_JUMP/ALU: ctr <= 11; target <= correct target.
  - Hit, FLOW_NONE with prediction (alias): valid <= 0.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target, ctr = 10 for COND or 11 for JUMP/ALU.
  - Miss and not taken: no write.
- Stats: when act and EX_flow_ty != FLOW_NONE, stat_branches += 1. When ex_miss, stat_mispredicts += 1. Both saturate at all-ones.

## Timing
- Prediction: zero latency; same-cycle combinational from IF_pc.
- Resteer/flush outputs: combinational, same cycle as the ID/EX inputs.
- Training write lands at the edge ending the EX cycle. A lookup of the same index in that cycle sees the old entry (no bypass).
- EX_stall=1 or EX_valid=0: no EX redirect, no training, no stat increment. ID-stage resteer is still evaluated.
- Reset (async, any time, including mid-training): all valid=0, ctr=00, targets=0, stats=0.
  - While rst is asserted: IF_pred_taken=0, IF_pred_tgt=0, stats=0. Resteer/flush outputs follow their combinational inputs.
- PRED_MODE=0: IF_pred_taken is always 0 and no table writes occur.
  - Behaviour is then identical to the not-taken controller: COND resteer only when taken; JUMP resteers in ID, and in EX only if mispredicted.

## Test plan
- Reset then COND at EX_pc=0x0040, EX_flag=1, tgt=0x0080, pred 0 -> IF_rewrite_pc=1, rewrite_to=0x0080, both flushes=1, stat_mispredicts=1. Next cycle IF_pc=0x0040 -> pred_taken=1, tgt=0x0080.
- Counter hysteresis: same branch taken once then not-taken once -> still predicted taken (ctr 11->10). Second not-taken -> predicted not-taken (01).
- Predicted-taken branch resolves not-taken at EX_pc=0x0040 -> rewrite_to=0x0042. Wrap case: EX_pc=0xFFFE -> rewrite_to=0x0000.
- Simultaneous ID JUMP miss (tgt 0x0100) and EX COND miss (tgt 0x0200) -> rewrite_to=0x0200, flush_id2ex=1.
- FLOW_ALU with pred_tgt=0x0300 and EX_alu_out=0x0304 -> redirect to 0x0304. Entry target is updated; EX_stall=1 in the same cycle -> no redirect, no update.
- Assert rst mid-run after 3 trained entries -> all predictions 0 and stats 0 immediately (asynchronously).

Source files
------------

// File: rtl/branch_predict_ctl_if.sv
// Pipeline-side bundle for the branch controller: fetch prediction,
// ID/EX verification inputs, resteer/flush outputs and statistics.
interface branch_predict_ctl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] IF_pc;
    logic             IF_pred_taken;
    logic [WIDTH-1:0] IF_pred_tgt;

    logic [1:0]       ID_flow_ty;
    logic [WIDTH-1:0] ID_dbranch_tgt;
    logic             ID_pred_taken;
    logic [WIDTH-1:0] ID_pred_tgt;

    logic             EX_valid;
    logic             EX_stall;
    logic [1:0]       EX_flow_ty;
    logic [WIDTH-1:0] EX_pc;
    logic [WIDTH-1:0] EX_dbranch_tgt;
    logic [WIDTH-1:0] EX_alu_out;
    logic             EX_flag;
    logic             EX_pred_taken;
    logic [WIDTH-1:0] EX_pred_tgt;

    logic             IF_rewrite_pc;
    logic [WIDTH-1:0] IF_pc_rewrite_to;
    logic             flush_if2id;
    logic             flush_id2ex;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    // Pipeline side: drives stage state, consumes prediction and resteer.
    modport master (
        output IF_pc, ID_flow_ty, ID_dbranch_tgt, ID_pred_taken, ID_pred_tgt,
               EX_valid, EX_stall, EX_flow_ty, EX_pc, EX_dbranch_tgt,
               EX_alu_out, EX_flag, EX_pred_taken, EX_pred_tgt,
        input  IF_pred_taken, IF_pred_tgt, IF_rewrite_pc, IF_pc_rewrite_to,
               flush_if2id, flush_id2ex, stat_branches, stat_mispredicts
    );

    // Controller side.
    modport slave (
        input  IF_pc, ID_flow_ty, ID_dbranch_tgt, ID_pred_taken, ID_pred_tgt,
               EX_valid, EX_stall, EX_flow_ty, EX_pc, EX_dbranch_tgt,
               EX_alu_out, EX_flag, EX_pred_taken, EX_pred_tgt,
        output IF_pred_taken, IF_pred_tgt, IF_rewrite_pc, IF_pc_rewrite_to,
               flush_if2id, flush_id2ex, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predict_ctl.sv
// Branch controller with a direct-mapped BTB and 2-bit bimodal counters.
// Predicts in IF, verifies direct jumps in ID and all flow in EX, resteers
// and flushes on mispredict, and trains the table when EX retires.
module branch_predict_ctl #(
    parameter int WIDTH     = 16,
    parameter int IDX_BITS  = 4,
    parameter int PRED_MODE = 1,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    branch_predict_ctl_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int          TAG_W   = WIDTH - IDX_BITS - 1;

    typedef enum logic [1:0] {
        FLOW_NONE = 2'd0,
        FLOW_JUMP = 2'd1,
        FLOW_COND = 2'd2,
        FLOW_ALU  = 2'd3
    } flow_t;

    logic             bt_valid [ENTRIES];
    logic [TAG_W-1:0] bt_tag   [ENTRIES];
    logic [WIDTH-1:0] bt_tgt   [ENTRIES];
    logic [1:0]       bt_ctr   [ENTRIES];

    logic [CNT_W-1:0] n_branches;
    logic [CNT_W-1:0] n_mispredicts;

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                if_hit;
    logic                ex_hit;
    flow_t               ex_flow;
    flow_t               id_flow;
    logic                ex_act;
    logic                ex_taken;
    logic [WIDTH-1:0]    ex_correct;
    logic                ex_miss;
    logic                id_miss;

    // Fetch-side lookup straight from the table registers.
    always_comb begin
        if_idx            = bus.IF_pc[IDX_BITS:1];
        if_hit            = bt_valid[if_idx] && (bt_tag[if_idx] == bus.IF_pc[WIDTH-1:IDX_BITS+1]);
        bus.IF_pred_taken = (PRED_MODE != 0) && if_hit && bt_ctr[if_idx][1];
        bus.IF_pred_tgt   = bus.IF_pred_taken ? bt_tgt[if_idx] : '0;
    end

    // Resolve EX/ID flow, detect mispredicts and pick the redirect target.
    always_comb begin
        ex_flow    = flow_t'(bus.EX_flow_ty);
        id_flow    = flow_t'(bus.ID_flow_ty);
        ex_act     = bus.EX_valid && !bus.EX_stall;
        ex_taken   = 1'b0;
        ex_correct = bus.EX_dbranch_tgt;
        unique case (ex_flow)
            FLOW_COND: ex_taken = bus.EX_flag;
            FLOW_JUMP: ex_taken = 1'b1;
            FLOW_ALU: begin
                ex_taken   = 1'b1;
                ex_correct = bus.EX_alu_out;
            end
            default:   ex_taken = 1'b0;
        endcase
        ex_miss = ex_act && ((ex_taken != bus.EX_pred_taken) ||
                             (ex_taken && (bus.EX_pred_tgt != ex_correct)));
        id_miss = (id_flow == FLOW_JUMP) &&
                  !(bus.ID_pred_taken && (bus.ID_pred_tgt == bus.ID_dbranch_tgt));
        ex_idx  = bus.EX_pc[IDX_BITS:1];
        ex_hit  = bt_valid[ex_idx] && (bt_tag[ex_idx] == bus.EX_pc[WIDTH-1:IDX_BITS+1]);

        bus.IF_rewrite_pc    = 1'b0;
        bus.IF_pc_rewrite_to = '0;
        bus.flush_if2id      = 1'b0;
        bus.flush_id2ex      = 1'b0;
        if (ex_miss) begin
            bus.IF_rewrite_pc    = 1'b1;
            bus.IF_pc_rewrite_to = ex_taken ? ex_correct : bus.EX_pc + WIDTH'(2);
            bus.flush_if2id      = 1'b1;
            bus.flush_id2ex      = 1'b1;
        end else if (id_miss) begin
            bus.IF_rewrite_pc    = 1'b1;
            bus.IF_pc_rewrite_to = bus.ID_dbranch_tgt;
            bus.flush_if2id      = 1'b1;
        end
        bus.stat_branches    = n_branches;
        bus.stat_mispredicts = n_mispredicts;
    end

    // Train the BTB entry addressed by EX_pc when EX retires an instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bt_valid[i] <= 1'b0;
                bt_tag[i]   <= '0;
                bt_tgt[i]   <= '0;
                bt_ctr[i]   <= '0;
            end
        end else if ((PRED_MODE != 0) && ex_act) begin
            if (ex_hit) begin
                unique case (ex_flow)
                    FLOW_COND: begin
                        if (ex_taken) begin
                            if (bt_ctr[ex_idx] != 2'b11) bt_ctr[ex_idx] <= bt_ctr[ex_idx] + 2'd1;
                            bt_tgt[ex_idx] <= ex_correct;
                        end else if (bt_ctr[ex_idx] != 2'b00) begin
                            bt_ctr[ex_idx] <= bt_ctr[ex_idx] - 2'd1;
                        end
                    end
                    FLOW_JUMP, FLOW_ALU: begin
                        bt_ctr[ex_idx] <= 2'b11;
                        bt_tgt[ex_idx] <= ex_correct;
                    end
                    default: begin
                        // A predicted non-branch means the entry aliases another PC.
                        if (bus.EX_pred_taken) bt_valid[ex_idx] <= 1'b0;
                    end
                endcase
            end else if (ex_taken) begin
                bt_valid[ex_idx] <= 1'b1;
                bt_tag[ex_idx]   <= bus.EX_pc[WIDTH-1:IDX_BITS+1];
                bt_tgt[ex_idx]   <= ex_correct;
                bt_ctr[ex_idx]   <= (ex_flow == FLOW_COND) ? 2'b10 : 2'b11;
            end
        end
    end

    // Saturating resolution and mispredict counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_branches    <= '0;
            n_mispredicts <= '0;
        end else begin
            if (ex_act && (ex_flow != FLOW_NONE) && (n_branches != '1))
                n_branches <= n_branches + CNT_W'(1);
            if (ex_miss && (n_mispredicts != '1))
                n_mispredicts <= n_mispredicts + CNT_W'(1);
        end
    end
endmodule
